// File: rtl/sa_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sa_fifo_pkg
// Shared constants for the 80x514 SRAM-backed FIFO controller and its skid
// queue, plus the circular-pointer increment used for both RAM pointers.
//   SA_DEPTH      RAM entries
//   SA_WIDTH      data width
//   SA_AW         RAM address width
//   SA_SKID_DEPTH output skid entries (also the number of read credits)
//   SA_CW         occupancy counter width, holds SA_DEPTH + SA_SKID_DEPTH
// ---------------------------------------------------------------------------
package sa_fifo_pkg;

    localparam int SA_DEPTH      = 80;
    localparam int SA_WIDTH      = 514;
    localparam int SA_AW         = 7;
    localparam int SA_SKID_DEPTH = 4;
    localparam int SA_CW         = 7;

    // Advance a RAM pointer, wrapping depth-1 -> 0 (depth need not be a
    // power of two, so a plain binary rollover is not enough).
    function automatic logic [SA_AW-1:0] ptr_inc(input logic [SA_AW-1:0] ptr,
                                                 input int depth);
        logic [SA_AW-1:0] nxt;
        nxt = ptr + SA_AW'(1);
        if (ptr == SA_AW'(depth - 1)) begin
            nxt = '0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sa_fifo_skid.sv
// ---------------------------------------------------------------------------
// sa_fifo_skid
// Small register FIFO that absorbs the SRAM read latency. Storage is plain
// flops, so the head word is available combinationally from registers.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   enqueue one word
//   pop               dequeue the head word (caller guarantees !empty)
//   head_data         current head word
//   count             words held (0..DEPTH)
//   full, empty       status flags
// ---------------------------------------------------------------------------
module sa_fifo_skid
    import sa_fifo_pkg::*;
#(
    parameter int DEPTH = SA_SKID_DEPTH,
    parameter int WIDTH = SA_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [NW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] entry_data [DEPTH];

    function automatic logic [PW-1:0] slot_inc(input logic [PW-1:0] p);
        logic [PW-1:0] nxt;
        nxt = p + PW'(1);
        if (p == PW'(DEPTH - 1)) begin
            nxt = '0;
        end
        return nxt;
    endfunction

    // One data register per slot; only the slot under the write pointer loads.
    // Data registers carry no reset: validity is tracked by count_reg alone.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    data_reg <= push_data;
                end
            end
            assign entry_data[gi] = data_reg;
        end
    endgenerate

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = slot_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = slot_inc(rd_ptr_reg);
        end
        count_next = count_reg + NW'(push) - NW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign head_data = entry_data[rd_ptr_reg];
    assign count     = count_reg;
    assign full      = (count_reg == NW'(DEPTH));
    assign empty     = (count_reg == '0);

    // A push into a full queue with no simultaneous pop would lose a word.
    skid_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && full && !pop));
    skid_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && empty));

endmodule

// File: rtl/sa_fifo_ctrl_80x514.sv
// ---------------------------------------------------------------------------
// sa_fifo_ctrl_80x514
// Turns an 80x514 two-port SRAM (registered read address + output register,
// two-cycle read latency) into a valid/ready FIFO. Writes go straight into
// the RAM; reads are issued against a credit count so that every word in
// flight has a guaranteed slot in the output skid queue.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready/in_data  upstream stream
//   out_valid/out_ready/out_data downstream stream (head of skid queue)
//   count                      words held: RAM + in flight + skid
//   ram_wa/ram_we/ram_di       RAM write port
//   ram_ra/ram_re/ram_ore      RAM read port (address latch, output reg)
//   ram_dout                   RAM read data
//   pwrbus_in -> ram_pwrbus_ram_pd  power bus pass-through
// ---------------------------------------------------------------------------
module sa_fifo_ctrl_80x514
    import sa_fifo_pkg::*;
#(
    parameter int DEPTH      = SA_DEPTH,
    parameter int WIDTH      = SA_WIDTH,
    parameter int AW         = SA_AW,
    parameter int SKID_DEPTH = SA_SKID_DEPTH,
    parameter int CW         = SA_CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic [AW-1:0]    ram_wa,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_di,
    output logic [AW-1:0]    ram_ra,
    output logic             ram_re,
    output logic             ram_ore,
    input  logic [WIDTH-1:0] ram_dout,
    input  logic [31:0]      pwrbus_in,
    output logic [31:0]      ram_pwrbus_ram_pd
);

    localparam int SNW = $clog2(SKID_DEPTH + 1);
    // Credit arithmetic spans p1 + p2 + skid occupancy, up to SKID_DEPTH + 2.
    localparam int KW  = SNW + 2;

    logic [AW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]  ram_count_reg, ram_count_next;
    logic [CW-1:0]  count_reg, count_next;
    logic           p1_reg, p2_reg;

    logic [SNW-1:0] skid_count;
    logic           skid_full, skid_empty;
    logic [WIDTH-1:0] skid_head;

    logic           wr_fire, issue, pop;
    logic [KW-1:0]  credits_used;

    // While reset is high the registers may still hold pre-reset state for
    // one cycle, so every handshake and RAM strobe is forced quiet here.
    always_comb begin
        in_ready     = ~reset & (ram_count_reg < CW'(DEPTH));
        wr_fire      = in_valid & in_ready;
        out_valid    = ~reset & ~skid_empty;
        pop          = out_valid & out_ready;
        // Slots already promised to reads in flight or held in the skid,
        // minus the one freed by this cycle's pop.
        credits_used = KW'(p1_reg) + KW'(p2_reg) + KW'(skid_count) - KW'(pop);
        issue        = ~reset & (ram_count_reg != '0)
                     & (credits_used < KW'(SKID_DEPTH));
    end

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        ram_count_next = ram_count_reg + CW'(wr_fire) - CW'(issue);
        count_next     = count_reg + CW'(wr_fire) - CW'(pop);
        if (wr_fire) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg, DEPTH);
        end
        if (issue) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg, DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            ram_count_reg <= '0;
            count_reg     <= '0;
            p1_reg        <= 1'b0;
            p2_reg        <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            ram_count_reg <= ram_count_next;
            count_reg     <= count_next;
            // p1: address latched this cycle, output register loads next.
            // p2: RAM output register now holds the word.
            p1_reg        <= issue;
            p2_reg        <= p1_reg;
        end
    end

    sa_fifo_skid #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (p2_reg & ~reset),
        .push_data (ram_dout),
        .pop       (pop),
        .head_data (skid_head),
        .count     (skid_count),
        .full      (skid_full),
        .empty     (skid_empty)
    );

    assign out_data          = skid_head;
    assign count             = reset ? '0 : count_reg;

    assign ram_we            = wr_fire;
    assign ram_wa            = wr_ptr_reg;
    assign ram_di            = in_data;
    assign ram_re            = issue;
    assign ram_ra            = rd_ptr_reg;
    assign ram_ore           = p1_reg & ~reset;
    assign ram_pwrbus_ram_pd = pwrbus_in;

    // Credits must keep the returning word from ever landing in a full skid.
    credit_guard: assert property (@(posedge clk) disable iff (reset)
        !(p2_reg && skid_full && !pop));
    count_bound: assert property (@(posedge clk) disable iff (reset)
        count_reg <= CW'(DEPTH + SKID_DEPTH));

endmodule

// File: tb/tb_sa_fifo_ctrl_80x514.sv
// ---------------------------------------------------------------------------
// tb_sa_fifo_ctrl_80x514
// Drives the FIFO controller together with a behavioural model of the
// two-cycle SRAM and compares everything against a queue-based reference.
// ---------------------------------------------------------------------------
module tb_sa_fifo_ctrl_80x514;
    import sa_fifo_pkg::*;

    localparam int DEPTH = SA_DEPTH;
    localparam int W     = SA_WIDTH;
    localparam int AW    = SA_AW;
    localparam int CW    = SA_CW;
    localparam int CAP   = SA_DEPTH + SA_SKID_DEPTH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;
    logic [AW-1:0] ram_wa, ram_ra;
    logic          ram_we, ram_re, ram_ore;
    logic [W-1:0]  ram_di, ram_dout;
    logic [31:0]   pwrbus_in = 32'h1234_5678;
    logic [31:0]   ram_pwrbus_ram_pd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sa_fifo_ctrl_80x514 dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .count             (count),
        .ram_wa            (ram_wa),
        .ram_we            (ram_we),
        .ram_di            (ram_di),
        .ram_ra            (ram_ra),
        .ram_re            (ram_re),
        .ram_ore           (ram_ore),
        .ram_dout          (ram_dout),
        .pwrbus_in         (pwrbus_in),
        .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
    );

    // SRAM model: registered read address, then output register.
    logic [W-1:0]  ram_mem [DEPTH];
    logic [AW-1:0] ram_ra_q;
    logic [W-1:0]  ram_dout_q;
    always @(posedge clk) begin
        if (ram_we)  ram_mem[ram_wa] <= ram_di;
        if (ram_re)  ram_ra_q <= ram_ra;
        if (ram_ore) ram_dout_q <= ram_mem[ram_ra_q];
    end
    assign ram_dout = ram_dout_q;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < 17; i++) w = {w[W-33:0], $urandom()};
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: words accepted but not yet popped, in order. Pointers are
    // simply the number of writes / read issues since reset, modulo DEPTH.
    logic [W-1:0] exp_q [$];
    int  wr_n = 0;
    int  rd_n = 0;
    int  pop_n = 0;
    logic prev_re = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            wr_n = 0;
            rd_n = 0;
            prev_re = 1'b0;
        end else begin
            chk("count", W'(count), W'(exp_q.size()));
            chk("ore_after_re", W'(ram_ore), W'(prev_re));
            chk("ram_we", W'(ram_we), W'(in_valid & in_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) chk("out_unexpected", W'(out_valid), W'(0));
                else                   chk("out_data", out_data, exp_q[0]);
            end
            if (ram_we) begin
                chk("ram_wa", W'(ram_wa), W'(wr_n % DEPTH));
                chk("ram_di", ram_di, in_data);
            end
            if (ram_re) begin
                chk("ram_ra", W'(ram_ra), W'(rd_n % DEPTH));
                rd_n++;
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                $display("pop %0d data[31:0]=%08h", pop_n, out_data[31:0]);
                void'(exp_q.pop_front());
                pop_n++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                wr_n++;
            end
            prev_re = ram_re;
        end
    end

    task automatic do_reset(input int n);
        tick();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (count != '0 && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("drain_empty", W'(count), W'(0));
    endtask

    task automatic write_n(input int n, input logic ordy);
        int got;
        int guard;
        got = 0;
        guard = 0;
        tick();
        out_ready = ordy;
        while (got < n && guard < 1000) begin
            in_valid = 1'b1;
            in_data = rand_word();
            @(negedge clk);
            if (in_ready) got++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        chk("write_n_accepted", W'(got), W'(n));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [W-1:0] pat;
        logic [W-1:0] mark;
        int n;
        int first;
        int bubbles;
        int stalls;
        int wait_cyc;
        bit done_rst;
        logic ov [0:219];

        // 1: reset behaviour
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", W'(in_ready), W'(0));
            chk("rst_out_valid", W'(out_valid), W'(0));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t1_in_ready", W'(in_ready), W'(1));
        chk("t1_out_valid", W'(out_valid), W'(0));
        chk("t1_count", W'(count), W'(0));
        chk("t1_strobes", W'({ram_we, ram_re, ram_ore}), W'(0));
        chk("t1_pwrbus", W'(ram_pwrbus_ram_pd), W'(32'h1234_5678));

        // 2: single word latency
        pat = W'(10'h2A5);
        tick();
        in_valid = 1'b1;
        in_data = pat;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_we_c0", W'(ram_we), W'(1));
        chk("t2_wa_c0", W'(ram_wa), W'(0));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_re_c1", W'(ram_re), W'(1));
        chk("t2_ra_c1", W'(ram_ra), W'(0));
        tick();
        @(negedge clk);
        chk("t2_ore_c2", W'(ram_ore), W'(1));
        chk("t2_re_c2", W'(ram_re), W'(0));
        tick();
        @(negedge clk);
        chk("t2_valid_c3", W'(out_valid), W'(0));
        tick();
        @(negedge clk);
        chk("t2_valid_c4", W'(out_valid), W'(1));
        chk("t2_data_c4", out_data, pat);
        tick();
        @(negedge clk);
        chk("t2_count_c5", W'(count), W'(0));
        chk("t2_valid_c5", W'(out_valid), W'(0));

        // 3: capacity with a stalled consumer
        do_reset(2);
        out_ready = 1'b0;
        n = 0;
        repeat (100) begin
            in_valid = 1'b1;
            in_data = W'(n);
            @(negedge clk);
            if (in_ready) n++;
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_accepted", W'(n), W'(CAP));
        chk("t3_in_ready", W'(in_ready), W'(0));
        chk("t3_count", W'(count), W'(CAP));
        chk("t3_out_valid", W'(out_valid), W'(1));
        chk("t3_head", out_data, W'(0));
        drain();

        // 4: pointer wrap-around
        do_reset(2);
        write_n(60, 1'b0);
        drain();
        write_n(60, 1'b1);
        drain();

        // 5: full-rate streaming
        do_reset(2);
        out_ready = 1'b1;
        stalls = 0;
        for (int k = 0; k < 200; k++) begin
            in_valid = 1'b1;
            in_data = W'(k);
            @(negedge clk);
            if (!in_ready) stalls++;
            ov[k] = out_valid;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 200; k < 220; k++) begin
            @(negedge clk);
            ov[k] = out_valid;
            tick();
        end
        first = -1;
        for (int k = 0; k < 220; k++) if (first < 0 && ov[k]) first = k;
        chk("t5_latency", W'(first), W'(4));
        bubbles = 0;
        for (int k = 4; k < 204; k++) if (!ov[k]) bubbles++;
        chk("t5_bubbles", W'(bubbles), W'(0));
        chk("t5_stalls", W'(stalls), W'(0));
        drain();

        // 6: random traffic with a reset while reads are in flight
        do_reset(2);
        done_rst = 1'b0;
        for (int k = 0; k < 300; k++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data = rand_word();
            out_ready = $urandom_range(0, 1) != 0;
            @(negedge clk);
            if (k >= 100 && !done_rst && ram_ore) begin
                tick();
                reset = 1'b1;
                in_valid = 1'b0;
                tick();
                reset = 1'b0;
                mark = rand_word();
                in_valid = 1'b1;
                in_data = mark;
                out_ready = 1'b0;
                @(negedge clk);
                chk("t6_valid_after_rst", W'(out_valid), W'(0));
                chk("t6_ready_after_rst", W'(in_ready), W'(1));
                tick();
                in_valid = 1'b0;
                out_ready = 1'b1;
                wait_cyc = 0;
                @(negedge clk);
                while (!out_valid && wait_cyc < 20) begin
                    tick();
                    @(negedge clk);
                    wait_cyc++;
                end
                chk("t6_first_word", out_data, mark);
                done_rst = 1'b1;
            end
            tick();
        end
        chk("t6_reset_done", W'(done_rst), W'(1));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
